// File: rtl/audcap_pkg.sv
// Shared definitions for the audio capture buffer.
//   - default geometry (sample width, frame depth, address width, timeout)
//   - signed sample typedef
//   - capture FSM state encoding
package audcap_pkg;

  localparam int AUDCAP_DATA_W       = 16;
  localparam int AUDCAP_DEPTH        = 640;
  localparam int AUDCAP_ADDR_W       = 10;
  localparam int AUDCAP_TRIG_TIMEOUT = 1024;

  typedef logic signed [AUDCAP_DATA_W-1:0] audcap_sample_t;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } audcap_state_t;

endpackage

// File: rtl/audcap_dpram.sv
// One bank of simple dual-port sample RAM: a synchronous write port and a
// registered read port on the same clock. Contents are never reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address (must be < DEPTH when we_i is high)
//   wdata_i : write data
//   raddr_i : read address (must be < DEPTH)
//   rdata_o : read data, one cycle after raddr_i
module audcap_dpram
  import audcap_pkg::*;
#(
  parameter int DATA_W = AUDCAP_DATA_W,
  parameter int DEPTH  = AUDCAP_DEPTH,
  parameter int ADDR_W = AUDCAP_ADDR_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/audio_capture_buffer.sv
// Triggered, double-buffered audio waveform capture for the VGA display.
// Picks one sample per codec LR frame (with optional decimation), waits for a
// rising zero crossing (or a timeout), captures DEPTH samples into the hidden
// bank and swaps it to the display side at the next frame boundary.
// All logic runs in the iCLK domain; iAud_LRCK is synchronised here.
//
// Optional feature macro: AUDCAP_PEAK_EN adds oPeak, the saturated max |sample|
// of the frame currently on display.
//
// Ports:
//   iCLK, iRST_N     : VGA control clock, async active-low reset
//   iAud_LRCK        : raw codec LR clock (asynchronous)
//   iAudL / iAudR    : signed samples, already in the iCLK domain
//   iChanSel         : 0 = left, 1 = right
//   iTrigEn          : 1 = wait for rising zero crossing, 0 = capture at once
//   iDecim           : keep 1 of every (iDecim+1) LR frames
//   iFrameDone       : one-cycle pulse at start of vertical blank
//   iVGA_X           : display read column
//   oSample          : sample at iVGA_X, one cycle later (0 if invalid/out of range)
//   oCapturing       : high while in CAPTURE
//   oTrigLost        : last capture was forced by timeout
//   oBankSel         : bank currently on display
//   oPeak            : (AUDCAP_PEAK_EN only) peak magnitude of displayed frame
module audio_capture_buffer
  import audcap_pkg::*;
#(
  parameter int DATA_W       = AUDCAP_DATA_W,
  parameter int DEPTH        = AUDCAP_DEPTH,
  parameter int ADDR_W       = AUDCAP_ADDR_W,
  parameter int TRIG_TIMEOUT = AUDCAP_TRIG_TIMEOUT
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic                     iAud_LRCK,
  input  logic signed [DATA_W-1:0] iAudL,
  input  logic signed [DATA_W-1:0] iAudR,
  input  logic                     iChanSel,
  input  logic                     iTrigEn,
  input  logic [3:0]               iDecim,
  input  logic                     iFrameDone,
  input  logic [ADDR_W-1:0]        iVGA_X,
  output logic signed [DATA_W-1:0] oSample,
  output logic                     oCapturing,
  output logic                     oTrigLost,
  output logic                     oBankSel
`ifdef AUDCAP_PEAK_EN
  ,
  output logic [DATA_W-1:0]        oPeak
`endif
);

  localparam int TMO_W = $clog2(TRIG_TIMEOUT + 1);

  // ---------------------------------------------------------------------------
  // LRCK synchroniser and strobe
  // ---------------------------------------------------------------------------
  logic [2:0] lrck_sync_q;
  logic       strobe_s;

  // Two flops for metastability, a third to detect the rising edge.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      lrck_sync_q <= 3'b000;
    end else begin
      lrck_sync_q <= {lrck_sync_q[1:0], iAud_LRCK};
    end
  end

  assign strobe_s = lrck_sync_q[1] & ~lrck_sync_q[2];

  // ---------------------------------------------------------------------------
  // Decimation: accept the strobe where the count is 0. The wrap limit is
  // sampled at each accepted strobe so a new iDecim applies from the next wrap.
  // ---------------------------------------------------------------------------
  logic [3:0] dec_cnt_q, dec_cnt_d;
  logic [3:0] dec_lim_q, dec_lim_d;
  logic [3:0] dec_lim_s;
  logic       acc_s;

  // Decimation counter next state.
  always_comb begin
    dec_cnt_d = dec_cnt_q;
    dec_lim_d = dec_lim_q;
    dec_lim_s = (dec_cnt_q == 4'd0) ? iDecim : dec_lim_q;
    acc_s     = strobe_s && (dec_cnt_q == 4'd0);
    if (strobe_s) begin
      if (dec_cnt_q == 4'd0) begin
        dec_lim_d = iDecim;
      end else begin
        dec_lim_d = dec_lim_q;
      end
      if (dec_cnt_q >= dec_lim_s) begin
        dec_cnt_d = 4'd0;
      end else begin
        dec_cnt_d = dec_cnt_q + 4'd1;
      end
    end else begin
      dec_cnt_d = dec_cnt_q;
    end
  end

  // Decimation registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      dec_cnt_q <= 4'd0;
      dec_lim_q <= 4'd0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      dec_lim_q <= dec_lim_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample path and trigger
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] sel_s;
  logic signed [DATA_W-1:0] prev_q;
  logic                     trig_s;

  assign sel_s  = iChanSel ? iAudR : iAudL;
  // Rising zero crossing: previous sample negative, current one non-negative.
  assign trig_s = ~iTrigEn | (prev_q[DATA_W-1] & ~sel_s[DATA_W-1]);

  // Previously accepted sample.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      prev_q <= {DATA_W{1'b0}};
    end else if (acc_s) begin
      prev_q <= sel_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  audcap_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [1:0]        valid_q, valid_d;
  logic              lost_q, lost_d;
  logic              bank_q, bank_d;
  logic              wbank_s;
  logic              tmo_exp_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic              cap_start_s;
  logic              swap_s;

  assign wbank_s   = ~bank_q;
  assign tmo_exp_s = (tmo_q == TMO_W'(TRIG_TIMEOUT - 1));

  // FSM next state and write-port control.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tmo_d       = tmo_q;
    valid_d     = valid_q;
    wr_en_s     = 1'b0;
    wr_addr_s   = addr_q;
    cap_start_s = 1'b0;
    swap_s      = 1'b0;
    case (state_q)
      ST_ARM: begin
        if (acc_s && (trig_s || tmo_exp_s)) begin
          wr_en_s     = 1'b1;
          wr_addr_s   = {ADDR_W{1'b0}};
          addr_d      = ADDR_W'(1);
          cap_start_s = 1'b1;
          state_d     = ST_CAPTURE;
        end else if (acc_s) begin
          tmo_d = tmo_q + TMO_W'(1);
        end else begin
          tmo_d = tmo_q;
        end
      end
      ST_CAPTURE: begin
        if (acc_s) begin
          wr_en_s = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          if (addr_q == ADDR_W'(DEPTH - 1)) begin
            valid_d[wbank_s] = 1'b1;
            state_d          = ST_DONE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end else begin
          addr_d = addr_q;
        end
      end
      ST_DONE: begin
        // A frame pulse seen in ARM/CAPTURE is deliberately not remembered.
        if (iFrameDone) begin
          swap_s  = 1'b1;
          tmo_d   = {TMO_W{1'b0}};
          state_d = ST_ARM;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_ARM;
      end
    endcase
  end

  // A natural trigger wins over a coincident timeout.
  assign lost_d = cap_start_s ? ~trig_s : lost_q;
  assign bank_d = swap_s ? ~bank_q : bank_q;

  // FSM registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_ARM;
      addr_q  <= {ADDR_W{1'b0}};
      tmo_q   <= {TMO_W{1'b0}};
      valid_q <= 2'b00;
      lost_q  <= 1'b0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      lost_q  <= lost_d;
      bank_q  <= bank_d;
    end
  end

  assign oCapturing = (state_q == ST_CAPTURE);
  assign oTrigLost  = lost_q;
  assign oBankSel   = bank_q;

  // ---------------------------------------------------------------------------
  // Sample RAM banks and read path
  // ---------------------------------------------------------------------------
  logic              in_range_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [DATA_W-1:0] rdata0_s, rdata1_s;
  logic              rd_ok_q;
  logic              rd_bank_q;

  assign in_range_s = ({1'b0, iVGA_X} < (ADDR_W + 1)'(DEPTH));
  assign rd_addr_s  = in_range_s ? iVGA_X : {ADDR_W{1'b0}};

  audcap_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank0 (
    .clk_i   (iCLK),
    .we_i    (wr_en_s & ~wbank_s),
    .waddr_i (wr_addr_s),
    .wdata_i (sel_s),
    .raddr_i (rd_addr_s),
    .rdata_o (rdata0_s)
  );

  audcap_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank1 (
    .clk_i   (iCLK),
    .we_i    (wr_en_s & wbank_s),
    .waddr_i (wr_addr_s),
    .wdata_i (sel_s),
    .raddr_i (rd_addr_s),
    .rdata_o (rdata1_s)
  );

  // Read qualifiers travel alongside the RAM read so they line up with rdata;
  // rd_ok_q also forces oSample to 0 the instant reset asserts.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rd_ok_q   <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      rd_ok_q   <= in_range_s & valid_q[bank_q];
      rd_bank_q <= bank_q;
    end
  end

  assign oSample = rd_ok_q ? (rd_bank_q ? rdata1_s : rdata0_s) : {DATA_W{1'b0}};

`ifdef AUDCAP_PEAK_EN
  // ---------------------------------------------------------------------------
  // Peak magnitude of the captured frame, published on the bank swap
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (!v[DATA_W-1]) begin
      r = v;
    end else if (v == {1'b1, {(DATA_W-1){1'b0}}}) begin
      r = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      r = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  logic [DATA_W-1:0] mag_s;
  logic [DATA_W-1:0] run_peak_q, run_peak_d;
  logic [DATA_W-1:0] peak_q, peak_d;

  // Running max restarts with the first write of each capture.
  always_comb begin
    mag_s      = abs_sat(sel_s);
    run_peak_d = run_peak_q;
    peak_d     = peak_q;
    if (cap_start_s) begin
      run_peak_d = mag_s;
    end else if (wr_en_s && (mag_s > run_peak_q)) begin
      run_peak_d = mag_s;
    end else begin
      run_peak_d = run_peak_q;
    end
    if (swap_s) begin
      peak_d = run_peak_q;
    end else begin
      peak_d = peak_q;
    end
  end

  // Peak registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      run_peak_q <= {DATA_W{1'b0}};
      peak_q     <= {DATA_W{1'b0}};
    end else begin
      run_peak_q <= run_peak_d;
      peak_q     <= peak_d;
    end
  end

  assign oPeak = peak_q;
`endif

endmodule

// File: tb/tb_audio_capture_buffer.sv
module tb_audio_capture_buffer;

  logic               iCLK = 1'b0;
  logic               iRST_N;
  logic               iAud_LRCK;
  logic signed [15:0] iAudL, iAudR;
  logic               iChanSel, iTrigEn;
  logic [3:0]         iDecim;
  logic               iFrameDone;
  logic [9:0]         iVGA_X;
  logic signed [15:0] oSample;
  logic               oCapturing, oTrigLost, oBankSel;
`ifdef AUDCAP_PEAK_EN
  logic [15:0]        oPeak;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 iCLK = ~iCLK;

  audio_capture_buffer dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iAud_LRCK  (iAud_LRCK),
    .iAudL      (iAudL),
    .iAudR      (iAudR),
    .iChanSel   (iChanSel),
    .iTrigEn    (iTrigEn),
    .iDecim     (iDecim),
    .iFrameDone (iFrameDone),
    .iVGA_X     (iVGA_X),
    .oSample    (oSample),
    .oCapturing (oCapturing),
    .oTrigLost  (oTrigLost),
    .oBankSel   (oBankSel)
`ifdef AUDCAP_PEAK_EN
    ,
    .oPeak      (oPeak)
`endif
  );

  // Triangle wave, period 14, between -1000 and +1000.
  function automatic logic signed [15:0] tri_val(input int k);
    case (k % 14)
      0:       return -16'sd1000;
      1:       return -16'sd700;
      2:       return -16'sd400;
      3:       return -16'sd100;
      4:       return 16'sd200;
      5:       return 16'sd500;
      6:       return 16'sd800;
      7:       return 16'sd1000;
      8:       return 16'sd700;
      9:       return 16'sd400;
      10:      return 16'sd100;
      11:      return -16'sd200;
      12:      return -16'sd500;
      default: return -16'sd800;
    endcase
  endfunction

  // One LR frame: 3 cycles high, 3 low. The DUT has acted on it on return.
  task automatic send(input logic signed [15:0] l, input logic signed [15:0] r);
    @(negedge iCLK);
    iAudL = l;
    iAudR = r;
    iAud_LRCK = 1'b1;
    repeat (3) @(negedge iCLK);
    iAud_LRCK = 1'b0;
    repeat (2) @(negedge iCLK);
  endtask

  task automatic pulse_frame_done();
    @(negedge iCLK);
    iFrameDone = 1'b1;
    @(negedge iCLK);
    iFrameDone = 1'b0;
  endtask

  task automatic read_x(input logic [9:0] x, output logic signed [15:0] v);
    @(negedge iCLK);
    iVGA_X = x;
    @(posedge iCLK);
    #1;
    v = oSample;
  endtask

  task automatic test_reset();
    logic signed [15:0] v;
    iRST_N = 1'b0;
    repeat (2) @(negedge iCLK);
    n_checks++;
    if ({oSample, oCapturing, oTrigLost, oBankSel} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {oSample, oCapturing, oTrigLost, oBankSel});
    end
    iRST_N = 1'b1;
    read_x(10'd0, v);
    n_checks++;
    if (v !== 16'sd0) begin n_fail++; $display("FAIL reset_read_x0: got %0d expected 0", v); end
    read_x(10'd639, v);
    n_checks++;
    if (v !== 16'sd0) begin n_fail++; $display("FAIL reset_read_x639: got %0d expected 0", v); end
  endtask

  task automatic test_trigger();
    logic signed [15:0] v;
    for (int k = 0; k < 4; k++) send(tri_val(k), 16'sd0);
    n_checks++;
    if (oCapturing !== 1'b0) begin n_fail++; $display("FAIL trig_armed: got %b expected 0", oCapturing); end
    send(tri_val(4), 16'sd0);
    n_checks++;
    if ({oCapturing, oTrigLost} !== 2'b10) begin
      n_fail++; $display("FAIL trig_start: got cap/lost %b expected 10", {oCapturing, oTrigLost});
    end
    for (int k = 5; k < 643; k++) send(tri_val(k), 16'sd0);
    n_checks++;
    if (oCapturing !== 1'b1) begin n_fail++; $display("FAIL trig_639th: got %b expected 1", oCapturing); end
    send(tri_val(643), 16'sd0);
    n_checks++;
    if (oCapturing !== 1'b0) begin n_fail++; $display("FAIL trig_done: got %b expected 0", oCapturing); end
    read_x(10'd0, v);
    n_checks++;
    if (v !== 16'sd0) begin n_fail++; $display("FAIL trig_preswap: got %0d expected 0", v); end
    send(16'sd500, 16'sd0);
    pulse_frame_done();
    n_checks++;
    if (oBankSel !== 1'b1) begin n_fail++; $display("FAIL trig_bank: got %b expected 1", oBankSel); end
    read_x(10'd0, v);
    n_checks++;
    if (v !== 16'sd200) begin n_fail++; $display("FAIL trig_x0: got %0d expected 200", v); end
    read_x(10'd1, v);
    n_checks++;
    if (v !== 16'sd500) begin n_fail++; $display("FAIL trig_x1: got %0d expected 500", v); end
    read_x(10'd639, v);
    n_checks++;
    if (v !== -16'sd800) begin n_fail++; $display("FAIL trig_x639: got %0d expected -800", v); end
  endtask

  task automatic test_frame_done_mid_capture();
    logic signed [15:0] v;
    iTrigEn  = 1'b0;
    iChanSel = 1'b1;
    for (int i = 0; i < 300; i++) send(16'sd999, -16'sd7);
    n_checks++;
    if (oCapturing !== 1'b1) begin n_fail++; $display("FAIL mid_capturing: got %b expected 1", oCapturing); end
    pulse_frame_done();
    n_checks++;
    if (oBankSel !== 1'b1) begin n_fail++; $display("FAIL mid_bank: got %b expected 1", oBankSel); end
    read_x(10'd1, v);
    n_checks++;
    if (v !== 16'sd500) begin n_fail++; $display("FAIL mid_old_wave: got %0d expected 500", v); end
    for (int i = 0; i < 340; i++) send(16'sd999, -16'sd7);
    n_checks++;
    if ({oCapturing, oBankSel} !== 2'b01) begin
      n_fail++; $display("FAIL mid_done_noswap: got cap/bank %b expected 01", {oCapturing, oBankSel});
    end
    send(16'sd999, 16'sd500);
    pulse_frame_done();
    n_checks++;
    if (oBankSel !== 1'b0) begin n_fail++; $display("FAIL mid_swap: got %b expected 0", oBankSel); end
    read_x(10'd5, v);
    n_checks++;
    if (v !== -16'sd7) begin n_fail++; $display("FAIL mid_new_x5: got %0d expected -7", v); end
    iChanSel = 1'b0;
  endtask

  task automatic test_timeout();
    logic signed [15:0] v;
    iTrigEn = 1'b1;
    for (int i = 0; i < 1023; i++) send(16'sd500, 16'sd0);
    n_checks++;
    if (oCapturing !== 1'b0) begin n_fail++; $display("FAIL tmo_hold: got %b expected 0", oCapturing); end
    send(16'sd500, 16'sd0);
    n_checks++;
    if ({oCapturing, oTrigLost} !== 2'b11) begin
      n_fail++; $display("FAIL tmo_forced: got cap/lost %b expected 11", {oCapturing, oTrigLost});
    end
    for (int i = 0; i < 639; i++) send(16'sd500, 16'sd0);
    n_checks++;
    if (oCapturing !== 1'b0) begin n_fail++; $display("FAIL tmo_done: got %b expected 0", oCapturing); end
    pulse_frame_done();
    n_checks++;
    if (oBankSel !== 1'b1) begin n_fail++; $display("FAIL tmo_bank: got %b expected 1", oBankSel); end
    read_x(10'd0, v);
    n_checks++;
    if (v !== 16'sd500) begin n_fail++; $display("FAIL tmo_x0: got %0d expected 500", v); end
    read_x(10'd639, v);
    n_checks++;
    if (v !== 16'sd500) begin n_fail++; $display("FAIL tmo_x639: got %0d expected 500", v); end
    read_x(10'd640, v);
    n_checks++;
    if (v !== 16'sd0) begin n_fail++; $display("FAIL tmo_x640: got %0d expected 0", v); end
    read_x(10'd700, v);
    n_checks++;
    if (v !== 16'sd0) begin n_fail++; $display("FAIL tmo_x700: got %0d expected 0", v); end
    read_x(10'd639, v);
    n_checks++;
    if (v !== 16'sd500) begin n_fail++; $display("FAIL tmo_x639_again: got %0d expected 500", v); end
  endtask

  task automatic test_reset_mid_capture();
    logic signed [15:0] v;
    iTrigEn = 1'b0;
    for (int i = 0; i < 300; i++) send(16'sd42, 16'sd0);
    read_x(10'd0, v);
    n_checks++;
    if ({v, oCapturing, oBankSel} !== {16'sd500, 2'b11}) begin
      n_fail++; $display("FAIL rstmid_before: got %0d/%b%b expected 500/11", v, oCapturing, oBankSel);
    end
    @(negedge iCLK);
    #3;
    iRST_N = 1'b0;
    #1;
    n_checks++;
    if ({oSample, oCapturing, oTrigLost, oBankSel} !== 19'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %h expected 0", {oSample, oCapturing, oTrigLost, oBankSel});
    end
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    read_x(10'd0, v);
    n_checks++;
    if (v !== 16'sd0) begin n_fail++; $display("FAIL rstmid_x0: got %0d expected 0", v); end
    iTrigEn = 1'b1;
    for (int i = 0; i < 5; i++) send(16'sd42, 16'sd0);
    n_checks++;
    if ({oCapturing, oBankSel} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_arm: got cap/bank %b expected 00", {oCapturing, oBankSel});
    end
  endtask

  task automatic test_decim();
    logic signed [15:0] v;
    iTrigEn = 1'b0;
    iDecim  = 4'd3;
    for (int n = 0; n < 2553; n++) send(16'(100 + n), 16'sd0);
    n_checks++;
    if (oCapturing !== 1'b1) begin n_fail++; $display("FAIL decim_639th: got %b expected 1", oCapturing); end
    for (int n = 2553; n < 2557; n++) send(16'(100 + n), 16'sd0);
    n_checks++;
    if (oCapturing !== 1'b0) begin n_fail++; $display("FAIL decim_done: got %b expected 0", oCapturing); end
    for (int n = 2557; n < 2560; n++) send(16'(100 + n), 16'sd0);
    iDecim = 4'd0;
    pulse_frame_done();
    n_checks++;
    if ({oBankSel, oTrigLost} !== 2'b10) begin
      n_fail++; $display("FAIL decim_bank: got bank/lost %b expected 10", {oBankSel, oTrigLost});
    end
    read_x(10'd0, v);
    n_checks++;
    if (v !== 16'sd100) begin n_fail++; $display("FAIL decim_x0: got %0d expected 100", v); end
    read_x(10'd1, v);
    n_checks++;
    if (v !== 16'sd104) begin n_fail++; $display("FAIL decim_x1: got %0d expected 104", v); end
    read_x(10'd2, v);
    n_checks++;
    if (v !== 16'sd108) begin n_fail++; $display("FAIL decim_x2: got %0d expected 108", v); end
    read_x(10'd639, v);
    n_checks++;
    if (v !== 16'sd2656) begin n_fail++; $display("FAIL decim_x639: got %0d expected 2656", v); end
  endtask

`ifdef AUDCAP_PEAK_EN
  task automatic test_peak();
    n_checks++;
    if (oPeak !== 16'd2656) begin n_fail++; $display("FAIL peak_ramp: got %0d expected 2656", oPeak); end
    iTrigEn = 1'b0;
    send(16'sd100, 16'sd0);
    send(-16'sd32768, 16'sd0);
    for (int i = 0; i < 638; i++) send(16'sd5, 16'sd0);
    pulse_frame_done();
    n_checks++;
    if (oPeak !== 16'd32767) begin n_fail++; $display("FAIL peak_sat: got %0d expected 32767", oPeak); end
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    iRST_N     = 1'b0;
    iAud_LRCK  = 1'b0;
    iAudL      = 16'sd0;
    iAudR      = 16'sd0;
    iChanSel   = 1'b0;
    iTrigEn    = 1'b1;
    iDecim     = 4'd0;
    iFrameDone = 1'b0;
    iVGA_X     = 10'd0;
    test_reset();
    test_trigger();
    test_frame_done_mid_capture();
    test_timeout();
    test_reset_mid_capture();
    test_decim();
`ifdef AUDCAP_PEAK_EN
    test_peak();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
